instr_encoder: RTL and testbench

Inverse of the front-end decoder: accepts an operation (`op_t`) plus operand fields on a valid/ready stream and emits the architecturally encoded 32-bit MIPS instruction word on an output valid/ready stream, buffered in a small FIFO. It serves the debug/self-test path, where a driver injects instruction sequences by operation name rather than by raw word. Every word it emits decodes back to the requested `op` through the front-end decoder; unencodable requests are flagged.

---
 rtl/instr_encoder_pkg.sv | 75 +++++++
 rtl/instr_encoder_fifo.sv | 67 ++++++
 rtl/instr_encoder.sv | 114 +++++++++++
 tb/tb_instr_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding table (opcodes, functs, REGIMM rt, COP0 rs) used by decoder and encoder.
// Also carries the common op_t / word_t types and small field-packing helpers.
package instr_encoder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [6:0] {
        OP_NOP, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
        OP_MOVZ, OP_MOVN, OP_SYSCALL, OP_BREAK, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_J, OP_JAL, OP_MFC0, OP_MTC0, OP_ERET,
        OP_MADD, OP_MADDU, OP_MUL, OP_MSUB, OP_MSUBU, OP_CLZ, OP_CLO,
        OP_DECODE_ERROR
    } op_t;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00, OPC_REGIMM = 6'h01, OPC_LUI = 6'h0F;
    localparam logic [5:0] OPC_COP0     = 6'h10, OPC_SPECIAL2 = 6'h1C;
    localparam logic [4:0] RT_BLTZ   = 5'b00000, RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000, RT_BGEZAL = 5'b10001;
    localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04, RS_CO = 5'h10;
    localparam logic [5:0] FN_ERET = 6'h18;

    function automatic logic [5:0] funct_of(input op_t op);
        case (op)
            OP_SLL:  return 6'h00;  OP_SRL:   return 6'h02;  OP_SRA:     return 6'h03;
            OP_SLLV: return 6'h04;  OP_SRLV:  return 6'h06;  OP_SRAV:    return 6'h07;
            OP_JR:   return 6'h08;  OP_JALR:  return 6'h09;  OP_MOVZ:    return 6'h0A;
            OP_MOVN: return 6'h0B;  OP_SYSCALL: return 6'h0C; OP_BREAK:  return 6'h0D;
            OP_MFHI: return 6'h10;  OP_MTHI:  return 6'h11;  OP_MFLO:    return 6'h12;
            OP_MTLO: return 6'h13;  OP_MULT:  return 6'h18;  OP_MULTU:   return 6'h19;
            OP_DIV:  return 6'h1A;  OP_DIVU:  return 6'h1B;  OP_ADD:     return 6'h20;
            OP_ADDU: return 6'h21;  OP_SUB:   return 6'h22;  OP_SUBU:    return 6'h23;
            OP_AND:  return 6'h24;  OP_OR:    return 6'h25;  OP_XOR:     return 6'h26;
            OP_NOR:  return 6'h27;  OP_SLT:   return 6'h2A;  OP_SLTU:    return 6'h2B;
            // SPECIAL2 function codes
            OP_MADD: return 6'h00;  OP_MADDU: return 6'h01;  OP_MUL:     return 6'h02;
            OP_MSUB: return 6'h04;  OP_MSUBU: return 6'h05;  OP_CLZ:     return 6'h20;
            OP_CLO:  return 6'h21;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] opcode_of(input op_t op);
        case (op)
            OP_J:    return 6'h02;  OP_JAL:   return 6'h03;  OP_BEQ:     return 6'h04;
            OP_BNE:  return 6'h05;  OP_BLEZ:  return 6'h06;  OP_BGTZ:    return 6'h07;
            OP_ADDI: return 6'h08;  OP_ADDIU: return 6'h09;  OP_SLTI:    return 6'h0A;
            OP_SLTIU: return 6'h0B; OP_ANDI:  return 6'h0C;  OP_ORI:     return 6'h0D;
            OP_XORI: return 6'h0E;  OP_LUI:   return OPC_LUI;
            OP_LB:   return 6'h20;  OP_LH:    return 6'h21;  OP_LW:      return 6'h23;
            OP_LBU:  return 6'h24;  OP_LHU:   return 6'h25;  OP_SB:      return 6'h28;
            OP_SH:   return 6'h29;  OP_SW:    return 6'h2B;
            default: return OPC_SPECIAL;
        endcase
    endfunction

    function automatic word_t r_word(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic word_t i_word(input logic [5:0] opc, input logic [4:0] rs, rt,
                                     input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic word_t sp2_word(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {OPC_SPECIAL2, rs, rt, rd, 5'd0, fn};
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with synchronous flush; pushes land at the head next cycle.
// push_rdy depends only on the stored count, so a full FIFO refuses a push even during a pop.
module instr_encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign push_rdy = count_q < CW'(DEPTH);
    assign pop_vld  = count_q != '0;
    assign pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign do_push  = push_vld && push_rdy && !flush;
    assign do_pop   = pop_vld && pop_rdy && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes an op_t plus operand fields into a MIPS word, queued in an output FIFO (1 cycle to head).
// in_ready = FIFO not full; INSTR_ENCODER_SPECIAL2_EN enables SPECIAL2 ops, otherwise they are errors.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  op_t         in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output word_t       out_instr,
    output logic        out_err,
    output logic [15:0] err_count
);
    word_t       enc_instr;
    logic        enc_err;
    logic        push_acc;
    logic [32:0] head_dat;
    logic [15:0] err_count_q, err_count_d;

    // Fields the format does not use are forced to zero rather than taken from the inputs.
    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (in_op)
            OP_NOP: enc_instr = '0;
            OP_SLL, OP_SRL, OP_SRA:
                enc_instr = r_word(5'd0, in_rt, in_rd, in_shamt, funct_of(in_op));
            OP_SLLV, OP_SRLV, OP_SRAV, OP_MOVZ, OP_MOVN, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
            OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU:
                enc_instr = r_word(in_rs, in_rt, in_rd, 5'd0, funct_of(in_op));
            OP_JR, OP_MTHI, OP_MTLO:
                enc_instr = r_word(in_rs, 5'd0, 5'd0, 5'd0, funct_of(in_op));
            OP_JALR:
                enc_instr = r_word(in_rs, 5'd0, in_rd, 5'd0, funct_of(in_op));
            OP_MFHI, OP_MFLO:
                enc_instr = r_word(5'd0, 5'd0, in_rd, 5'd0, funct_of(in_op));
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:
                enc_instr = r_word(in_rs, in_rt, 5'd0, 5'd0, funct_of(in_op));
            OP_SYSCALL, OP_BREAK:
                enc_instr = r_word(5'd0, 5'd0, 5'd0, 5'd0, funct_of(in_op));
            OP_BLTZ:   enc_instr = i_word(OPC_REGIMM, in_rs, RT_BLTZ, in_imm);
            OP_BGEZ:   enc_instr = i_word(OPC_REGIMM, in_rs, RT_BGEZ, in_imm);
            OP_BLTZAL: enc_instr = i_word(OPC_REGIMM, in_rs, RT_BLTZAL, in_imm);
            OP_BGEZAL: enc_instr = i_word(OPC_REGIMM, in_rs, RT_BGEZAL, in_imm);
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
                enc_instr = i_word(opcode_of(in_op), in_rs, in_rt, in_imm);
            OP_BLEZ, OP_BGTZ:
                enc_instr = i_word(opcode_of(in_op), in_rs, 5'd0, in_imm);
            OP_LUI:    enc_instr = i_word(OPC_LUI, 5'd0, in_rt, in_imm);
            OP_J, OP_JAL: enc_instr = {opcode_of(in_op), in_target};
            OP_MFC0:   enc_instr = {OPC_COP0, RS_MF, in_rt, in_rd, 8'h00, in_imm[2:0]};
            OP_MTC0:   enc_instr = {OPC_COP0, RS_MT, in_rt, in_rd, 8'h00, in_imm[2:0]};
            OP_ERET:   enc_instr = {OPC_COP0, RS_CO, 15'h0000, FN_ERET};
`ifdef INSTR_ENCODER_SPECIAL2_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:
                enc_instr = sp2_word(in_rs, in_rt, 5'd0, funct_of(in_op));
            OP_MUL, OP_CLZ, OP_CLO:
                enc_instr = sp2_word(in_rs, in_rt, in_rd, funct_of(in_op));
`endif
            default:   enc_err = 1'b1;
        endcase
    end

    // A push dropped by flush must not count as an accepted error.
    assign push_acc = in_valid && in_ready && !flush;

    always_comb begin
        err_count_d = err_count_q;
        if (push_acc && enc_err && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    instr_encoder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .flush    (flush),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat ({enc_err, enc_instr}),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat)
    );

    assign out_instr = head_dat[31:0];
    assign out_err   = head_dat[32];
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words are queued on accept and popped when the DUT emits.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    op_t         in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid, out_ready, out_err;
    word_t       out_instr;
    logic [15:0] err_count;

    int          checks = 0;
    int          failures = 0;
    int          exp_err_cnt = 0;
    logic [32:0] sb[$];
    logic [32:0] e;

`ifdef INSTR_ENCODER_SPECIAL2_EN
    localparam logic [32:0] MUL_EXP = {1'b0, 32'h7064_1002};
`else
    localparam logic [32:0] MUL_EXP = {1'b1, 32'h0000_0000};
`endif
    localparam logic [32:0] ERR_EXP = {1'b1, 32'h0000_0000};

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input op_t op, input logic [4:0] rs, rt, rd, sh,
                         input logic [15:0] imm, input logic [25:0] tgt);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt;
    endtask

    task automatic send(input string tag, input op_t op, input logic [4:0] rs, rt, rd, sh,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic [32:0] exp);
        int waited;
        waited = 0;
        drive(op, rs, rt, rd, sh, imm, tgt);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (out_valid && !out_ready && sb.size() > 0)
            chk({tag, "_hold"}, 64'({out_err, out_instr}), 64'(sb[0]));
        chk({tag, "_accept"}, 64'(in_ready), 64'(1));
        if (in_ready) begin
            sb.push_back(exp);
            if (exp[32]) exp_err_cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_ori(input string tag, input int i);
        send(tag, OP_ORI, 5'd1, 5'd2, 5'd7, 5'd7, 16'(i), 26'h3FF_FFFF,
             {1'b0, 32'h3422_0000 | 32'(i)});
    endtask

    task automatic recv(input string tag);
        int waited;
        logic [32:0] exp;
        waited = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_latency"}, 64'(waited), 64'(0));
        chk({tag, "_present"}, 64'(out_valid && sb.size() > 0), 64'(1));
        if (out_valid && sb.size() > 0) begin
            exp = sb.pop_front();
            chk({tag, "_word"}, 64'({out_err, out_instr}), 64'(exp));
        end
        chk({tag, "_errcnt"}, 64'(err_count), 64'(exp_err_cnt));
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(OP_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Encodings; junk in ignored fields must not leak into the word.
        send("addiu", OP_ADDIU, 5'd29, 5'd29, 5'd3, 5'd3, 16'hFFF8, 26'h155, {1'b0, 32'h27BD_FFF8});
        recv("addiu");
        send("jal", OP_JAL, 5'd5, 5'd6, 5'd7, 5'd8, 16'h1234, 26'h010_0000, {1'b0, 32'h0C10_0000});
        recv("jal");
        send("lw", OP_LW, 5'd29, 5'd8, 5'd31, 5'd31, 16'h0004, 26'd0, {1'b0, 32'h8FA8_0004});
        recv("lw");
        send("bgezal", OP_BGEZAL, 5'd4, 5'd7, 5'd9, 5'd1, 16'h0000, 26'd0, {1'b0, 32'h0491_0000});
        recv("bgezal");
        send("eret", OP_ERET, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, {1'b0, 32'h4200_0018});
        recv("eret");
        send("syscall", OP_SYSCALL, 5'd9, 5'd10, 5'd11, 5'd12, 16'hABCD, 26'd0, {1'b0, 32'h0000_000C});
        recv("syscall");
        send("sll", OP_SLL, 5'd7, 5'd9, 5'd10, 5'd3, 16'hFFFF, 26'd0, {1'b0, 32'h0009_50C0});
        recv("sll");
        send("blez", OP_BLEZ, 5'd5, 5'd7, 5'd0, 5'd0, 16'h0010, 26'd0, {1'b0, 32'h18A0_0010});
        recv("blez");
        send("lui", OP_LUI, 5'd3, 5'd8, 5'd0, 5'd0, 16'h1234, 26'd0, {1'b0, 32'h3C08_1234});
        recv("lui");
        send("mfc0", OP_MFC0, 5'd21, 5'd8, 5'd12, 5'd9, 16'hFFF5, 26'd0, {1'b0, 32'h4008_6005});
        recv("mfc0");
        send("nop", OP_NOP, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h2AA, {1'b0, 32'h0000_0000});
        recv("nop");
        send("mul", OP_MUL, 5'd3, 5'd4, 5'd2, 5'd0, 16'd0, 26'd0, MUL_EXP);
        recv("mul");
        send("decerr", OP_DECODE_ERROR, 5'd1, 5'd2, 5'd3, 5'd4, 16'h7777, 26'd5, ERR_EXP);
        recv("decerr");
        send("unlisted", op_t'(7'd100), 5'd1, 5'd2, 5'd3, 5'd4, 16'h7777, 26'd5, ERR_EXP);
        recv("unlisted");

        // Backpressure: fill to DEPTH, then a pop in the same cycle must not admit the 5th push.
        for (int i = 0; i < 4; i++) send_ori("bp_fill", i);
        drive(OP_ORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_full_in_ready", 64'(in_ready), 64'(0));
        chk("bp_full_hold", 64'({out_err, out_instr}), 64'(sb[0]));
        out_ready = 1'b1;
        e = sb.pop_front();
        chk("bp_pop_while_full", 64'({out_err, out_instr}), 64'(e));
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_push_refused", 64'(in_ready), 64'(1));
        sb.push_back({1'b0, 32'h3422_0004});
        @(posedge clk); #1;
        in_valid = 1'b0;
        recv("bp_drain");

        // Simultaneous push and pop at count 3 keeps count at 3.
        drive(OP_ORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'd5, 26'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pp_in_ready", 64'(in_ready), 64'(1));
        e = sb.pop_front();
        chk("pp_pop", 64'({out_err, out_instr}), 64'(e));
        sb.push_back({1'b0, 32'h3422_0005});
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) recv("pp_drain");
        @(negedge clk);
        chk("pp_empty", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        // Flush at count 3 with a concurrent erroring push.
        for (int i = 6; i < 9; i++) send_ori("fl_fill", i);
        drive(OP_DECODE_ERROR, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("fl_out_valid", 64'(out_valid), 64'(0));
        chk("fl_in_ready", 64'(in_ready), 64'(1));
        chk("fl_err_count", 64'(err_count), 64'(exp_err_cnt));
        @(posedge clk); #1;
        send_ori("fl_after", 9);
        recv("fl_after");

        // Asynchronous reset mid-stream with two entries queued.
        send_ori("rs_fill", 10);
        send_ori("rs_fill", 11);
        #2 reset = 1'b1;
        #1;
        chk("rs_out_valid", 64'(out_valid), 64'(0));
        chk("rs_in_ready", 64'(in_ready), 64'(1));
        chk("rs_out_instr", 64'(out_instr), 64'(0));
        chk("rs_err_count", 64'(err_count), 64'(0));
        sb.delete();
        exp_err_cnt = 0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        send_ori("rs_after", 12);
        recv("rs_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
